// File: rtl/op_unit_sched_if.sv
// Purpose: bundles the two operand request ports, the tagged result port, en and busy of op_unit_sched.
// Latency: none, this file only carries signals.
// Backpressure: valid/ready on each requester and on the result; ready is driven by the receiving side.
// Optional: OP_UNIT_SCHED_STATS_EN adds the gnt_cnt0/gnt_cnt1 grant counters to the bundle.
interface op_unit_sched_if #(
    parameter int CW = 8
);
    localparam int ZW = $clog2(CW + 1);

    logic              en;

    logic              req0_valid;
    logic              req0_ready;
    logic [2*CW-1:0]   req0_a;
    logic [2*CW-1:0]   req0_b;
    logic [CW-1:0]     req0_c;

    logic              req1_valid;
    logic              req1_ready;
    logic [2*CW-1:0]   req1_a;
    logic [2*CW-1:0]   req1_b;
    logic [CW-1:0]     req1_c;

    logic              res_valid;
    logic              res_ready;
    logic              res_id;
    logic [CW-1:0]     res_x;
    logic [CW-1:0]     res_y;
    logic [ZW-1:0]     res_z;
    logic              res_w;

    logic              busy;

`ifdef OP_UNIT_SCHED_STATS_EN
    logic [15:0]       gnt_cnt0;
    logic [15:0]       gnt_cnt1;

    // Producer/consumer side: drives operands, en and res_ready.
    modport master (
        output en,
        output req0_valid, req0_a, req0_b, req0_c,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_c,
        input  req1_ready,
        input  res_valid, res_id, res_x, res_y, res_z, res_w,
        output res_ready,
        input  busy,
        input  gnt_cnt0, gnt_cnt1
    );

    // Scheduler side.
    modport slave (
        input  en,
        input  req0_valid, req0_a, req0_b, req0_c,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_c,
        output req1_ready,
        output res_valid, res_id, res_x, res_y, res_z, res_w,
        input  res_ready,
        output busy,
        output gnt_cnt0, gnt_cnt1
    );
`else
    // Producer/consumer side: drives operands, en and res_ready.
    modport master (
        output en,
        output req0_valid, req0_a, req0_b, req0_c,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_c,
        input  req1_ready,
        input  res_valid, res_id, res_x, res_y, res_z, res_w,
        output res_ready,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  en,
        input  req0_valid, req0_a, req0_b, req0_c,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_c,
        output req1_ready,
        output res_valid, res_id, res_x, res_y, res_z, res_w,
        input  res_ready,
        output busy
    );
`endif

endinterface

// File: rtl/op_unit_sched.sv
// Purpose: round-robin scheduler for two requesters around a bit-serial compare/logic/popcount/parity unit.
// Latency: res_valid rises CW+1 cycles after the accepting edge; one operation in flight at a time.
// Backpressure: requesters are granted only in IDLE with en=1; the result holds in DONE until res_ready.
// Optional: define OP_UNIT_SCHED_STATS_EN to add saturating 16-bit grant counters gnt_cnt0/gnt_cnt1.
module op_unit_sched #(
    parameter int CW = 8            // must match the CW of the connected op_unit_sched_if
) (
    input  logic             clk,
    input  logic             rst,
    op_unit_sched_if.slave   bus
);

    localparam int ZW   = $clog2(CW + 1);
    localparam int CNTW = $clog2(CW + 1);

    // Alternating 1010... mask (MSB set), forced into aux so its parity never collapses to the raw operands.
    function automatic logic [CW-1:0] alt_pattern();
        logic [CW-1:0] p;
        for (int i = 0; i < CW; i++) begin
            p[i] = (i % 2) == 1;
        end
        return p;
    endfunction

    localparam logic [CW-1:0] AUX_PAT = alt_pattern();

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic              rr_ptr;      // id of the last granted requester
    logic              busy_q;

    // Per-operation working state.
    logic              id_q;
    logic [CW-1:0]     x_q;
    logic [CW-1:0]     y_q;
    logic [CW-1:0]     c_sh;
    logic [CW-1:0]     aux_sh;
    logic [ZW-1:0]     z_acc;
    logic              w_acc;
    logic [CNTW-1:0]   bit_cnt;

    // Published result registers; they keep their value between operations.
    logic              res_valid_q;
    logic              res_id_q;
    logic [CW-1:0]     res_x_q;
    logic [CW-1:0]     res_y_q;
    logic [ZW-1:0]     res_z_q;
    logic              res_w_q;

    // Grant and operand selection.
    logic              gnt_ok;
    logic              gnt_id;
    logic              accept;
    logic [2*CW-1:0]   op_a;
    logic [2*CW-1:0]   op_b;
    logic [CW-1:0]     op_c;
    logic [CW-1:0]     a_hi;
    logic [CW-1:0]     a_lo;
    logic [CW-1:0]     b_hi;
    logic [CW-1:0]     b_lo;
    logic [CW-1:0]     x_nxt;
    logic [CW-1:0]     y_nxt;
    logic [CW-1:0]     aux_nxt;

    // Arbitration: single requester wins outright, a tie goes to the one not granted last time.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = 1'b0;
        if (state == IDLE && bus.en && (bus.req0_valid || bus.req1_valid)) begin
            gnt_ok = 1'b1;
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_id = ~rr_ptr;
            end else begin
                gnt_id = bus.req1_valid;
            end
        end
    end

    // Ready is only ever offered to the granted requester, so a grant is also an accept.
    assign accept         = gnt_ok;
    assign bus.req0_ready = gnt_ok & ~gnt_id;
    assign bus.req1_ready = gnt_ok &  gnt_id;

    // Operand mux and the parallel part of the operation (x, y and the aux word to be reduced).
    always_comb begin
        op_a    = gnt_id ? bus.req1_a : bus.req0_a;
        op_b    = gnt_id ? bus.req1_b : bus.req0_b;
        op_c    = gnt_id ? bus.req1_c : bus.req0_c;
        a_hi    = op_a[2*CW-1:CW];
        a_lo    = op_a[CW-1:0];
        b_hi    = op_b[2*CW-1:CW];
        b_lo    = op_b[CW-1:0];
        x_nxt   = (a_hi > a_lo) ? a_hi : a_lo;
        y_nxt   = (b_hi & a_hi) ^ (b_lo | a_lo);
        aux_nxt = (op_c ^ (b_hi & a_lo)) | AUX_PAT;
    end

    // Scheduler FSM: accept in IDLE, shift one bit per cycle in COMPUTE, publish and hold in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b1;
            busy_q      <= 1'b0;
            id_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            c_sh        <= '0;
            aux_sh      <= '0;
            z_acc       <= '0;
            w_acc       <= 1'b0;
            bit_cnt     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            res_z_q     <= '0;
            res_w_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q    <= gnt_id;
                        x_q     <= x_nxt;
                        y_q     <= y_nxt;
                        c_sh    <= op_c;
                        aux_sh  <= aux_nxt;
                        z_acc   <= '0;
                        w_acc   <= 1'b0;
                        bit_cnt <= '0;
                        rr_ptr  <= gnt_id;
                        busy_q  <= 1'b1;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    z_acc   <= z_acc + ZW'(c_sh[0]);
                    w_acc   <= w_acc ^ aux_sh[0];
                    c_sh    <= c_sh >> 1;
                    aux_sh  <= aux_sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNTW'(CW - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle copies the finished accumulators out; afterwards wait for the consumer.
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                        res_x_q     <= x_q;
                        res_y_q     <= y_q;
                        res_z_q     <= z_acc;
                        res_w_q     <= w_acc;
                    end else if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_x     = res_x_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_z     = res_z_q;
    assign bus.res_w     = res_w_q;
    assign bus.busy      = busy_q;

`ifdef OP_UNIT_SCHED_STATS_EN
    logic [15:0] gnt_cnt0_q;
    logic [15:0] gnt_cnt1_q;

    // Per-requester accept counters, saturating so a long run never wraps back to a small number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else if (accept) begin
            if (!gnt_id && gnt_cnt0_q != 16'hFFFF) begin
                gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            end
            if (gnt_id && gnt_cnt1_q != 16'hFFFF) begin
                gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
            end
        end
    end

    assign bus.gnt_cnt0 = gnt_cnt0_q;
    assign bus.gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_op_unit_sched.sv
// Purpose: bench for op_unit_sched; directed scenarios plus randomized traffic against a behavioural model.
// Latency: the model expects res_valid CW+1 cycles after each accept.
// Backpressure: res_ready and en are randomized; the model predicts every ready and result cycle.
module tb_op_unit_sched;

    localparam int CW = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    op_unit_sched_if #(.CW(CW)) bus ();

    op_unit_sched #(.CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] z;
        logic       w;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference operation written straight from the arithmetic definition.
    function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
        res_t r;
        logic [7:0] aux;
        r.x = (a[15:8] > a[7:0]) ? a[15:8] : a[7:0];
        r.y = (b[15:8] & a[15:8]) ^ (b[7:0] | a[7:0]);
        r.z = 4'($countones(c));
        aux = (c ^ (b[15:8] & a[7:0])) | 8'hAA;
        r.w = ^aux;
        return r;
    endfunction

    // Model state: one transaction at most, remembered by accept cycle and expected result.
    bit   m_busy = 1'b0;
    bit   m_last = 1'b1;
    int   m_acc_cyc;
    res_t m_exp;
    bit   m_exp_id;
    int   m_cnt0;
    int   m_cnt1;

    // Cycle-by-cycle monitor: predicts readys, busy, res_valid timing and the result payload.
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            bit v0, v1, eg, ew, erv;
            v0  = bus.req0_valid;
            v1  = bus.req1_valid;
            eg  = !m_busy && bus.en && (v0 || v1);
            ew  = (v0 && v1) ? !m_last : v1;
            erv = m_busy && (cyc - m_acc_cyc >= 9);
            chk("mon_req0_ready", 32'(bus.req0_ready), 32'(eg && !ew));
            chk("mon_req1_ready", 32'(bus.req1_ready), 32'(eg && ew));
            chk("mon_busy", 32'(bus.busy), 32'(m_busy));
            chk("mon_res_valid", 32'(bus.res_valid), 32'(erv));
`ifdef OP_UNIT_SCHED_STATS_EN
            chk("mon_gnt_cnt0", 32'(bus.gnt_cnt0), 32'(m_cnt0));
            chk("mon_gnt_cnt1", 32'(bus.gnt_cnt1), 32'(m_cnt1));
`endif
            if (erv && bus.res_valid) begin
                chk("mon_res_id", 32'(bus.res_id), 32'(m_exp_id));
                chk("mon_res_x", 32'(bus.res_x), 32'(m_exp.x));
                chk("mon_res_y", 32'(bus.res_y), 32'(m_exp.y));
                chk("mon_res_z", 32'(bus.res_z), 32'(m_exp.z));
                chk("mon_res_w", 32'(bus.res_w), 32'(m_exp.w));
                if (bus.res_ready) m_busy = 1'b0;
            end
            if (eg) begin
                m_exp    = ew ? ref_op(bus.req1_a, bus.req1_b, bus.req1_c)
                              : ref_op(bus.req0_a, bus.req0_b, bus.req0_c);
                m_exp_id  = ew;
                m_last    = ew;
                m_busy    = 1'b1;
                m_acc_cyc = cyc + 1;
                if (ew) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
                else    m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until res_valid is seen; an expired budget is reported as a failed check.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.res_valid) break;
        end
        if (!bus.res_valid) chk("wait_valid_timeout", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_req(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c;
        end
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.en         = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0;
        bus.res_ready  = 1'b0;

        // Reset state.
        #2;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);
        chk("rst_res_x", 32'(bus.res_x), 32'd0);
        chk("rst_res_y", 32'(bus.res_y), 32'd0);
        chk("rst_res_z", 32'(bus.res_z), 32'd0);
        chk("rst_res_w", 32'(bus.res_w), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Requester 0 alone.
        bus.res_ready = 1'b1;
        drive_req(1'b0, 16'h1234, 16'h5678, 8'h0F);
        #1 chk("t1_ready", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        wait_valid(lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_id", 32'(bus.res_id), 32'd0);
        chk("t1_x", 32'(bus.res_x), 32'h34);
        chk("t1_y", 32'(bus.res_y), 32'h6E);
        chk("t1_z", 32'(bus.res_z), 32'd4);
        chk("t1_w", 32'(bus.res_w), 32'd0);
        step();

        // Requester 1 alone.
        drive_req(1'b1, 16'h0000, 16'h0000, 8'h01);
        step();
        bus.req1_valid = 1'b0;
        wait_valid(lat);
        chk("t2_latency", 32'(lat), 32'd9);
        chk("t2_id", 32'(bus.res_id), 32'd1);
        chk("t2_x", 32'(bus.res_x), 32'd0);
        chk("t2_y", 32'(bus.res_y), 32'd0);
        chk("t2_z", 32'(bus.res_z), 32'd1);
        chk("t2_w", 32'(bus.res_w), 32'd1);
        step();

        // Both valid continuously after reset: strict alternation starting with requester 0.
        pulse_reset();
        drive_req(1'b0, 16'h0000, 16'h0000, 8'hFF);
        drive_req(1'b1, 16'h0000, 16'h0000, 8'hF0);
        for (int k = 0; k < 4; k++) begin
            wait_valid(lat);
            chk("t3_id", 32'(bus.res_id), 32'(k % 2));
            chk("t3_z", 32'(bus.res_z), (k % 2) ? 32'd4 : 32'd8);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        // Consumer stall in DONE.
        bus.res_ready = 1'b0;
        drive_req(1'b0, 16'hA05F, 16'h3C81, 8'h5A);
        step();
        bus.req0_valid = 1'b0;
        wait_valid(lat);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_valid", 32'(bus.res_valid), 32'd1);
            chk("t4_x", 32'(bus.res_x), 32'hA0);
            chk("t4_y", 32'(bus.res_y), 32'hFF);
            chk("t4_z", 32'(bus.res_z), 32'd4);
            chk("t4_w", 32'(bus.res_w), 32'd0);
            chk("t4_ready0", 32'(bus.req0_ready), 32'd0);
            chk("t4_ready1", 32'(bus.req1_ready), 32'd0);
            chk("t4_busy", 32'(bus.busy), 32'd1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        step();
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        chk("t4_idle_valid", 32'(bus.res_valid), 32'd0);

        // Reset three cycles into an operation granted to requester 0.
        drive_req(1'b0, 16'hFFFF, 16'h1111, 8'h33);
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_valid", 32'(bus.res_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t5_no_result", 32'(bus.res_valid), 32'd0);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("t5_tie_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t5_tie_ready1", 32'(bus.req1_ready), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        // en low blocks grants; raising it grants in the same cycle.
        pulse_reset();
        bus.en = 1'b0;
        drive_req(1'b0, 16'h00FF, 16'h0F0F, 8'h80);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_ready_blocked", 32'(bus.req0_ready), 32'd0);
        end
        bus.en = 1'b1;
        #1 chk("t6_ready_en", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        chk("t6_busy", 32'(bus.busy), 32'd1);
`ifdef OP_UNIT_SCHED_STATS_EN
        chk("t6_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd1);
`endif
        wait_valid(lat);
        chk("t6_latency", 32'(lat), 32'd9);
        step();

        // Randomized traffic, checked entirely by the monitor.
        for (int k = 0; k < 1500; k++) begin
            bus.en         = ($urandom_range(0, 7) != 0);
            bus.res_ready  = ($urandom_range(0, 3) != 0);
            bus.req0_valid = $urandom_range(0, 1);
            bus.req1_valid = $urandom_range(0, 1);
            bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_c = 8'($urandom);
            bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_c = 8'($urandom);
            step();
        end

        // Drain.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.en         = 1'b1;
        bus.res_ready  = 1'b1;
        for (int k = 0; k < 40 && bus.busy; k++) step();
        chk("drain_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
